// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: parity selection and TX FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Turns the XOR reduction of the payload into the bit sent on the line.
  function automatic logic parity_bit(input logic data_xor, input parity_e mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy count distinguishes full from empty, pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             wr_data,
  output logic [width-1:0]             rd_data,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO; frames run back-to-back while words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 20000,
  parameter int unsigned data_bits      = 8,
  parameter parity_e     parity_mode    = PARITY_NONE,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned fifo_depth     = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [data_bits-1:0]                i_data,
  input  logic                                i_valid,
  output logic                                o_ready,
  output logic                                o_serial,
  output logic                                o_busy,
  output logic [$clog2(fifo_depth+1)-1:0]     o_count
);

  localparam logic [15:0] BIT_LOAD   = 16'(clocks_per_bit - 1);
  localparam logic [3:0]  LAST_DATA  = 4'(data_bits - 1);
  localparam logic        STOP_LAST  = 1'(stop_bits - 1);
  localparam bit          HAS_PARITY = (parity_mode != PARITY_NONE);

  tx_state_e            state_q, state_d;
  logic                 serial_q, serial_d;
  logic [15:0]          timer_q, timer_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [data_bits-1:0] fifo_head;
  logic                 bit_done;
  logic                 start_frame;

  assign o_ready   = !fifo_full;
  assign fifo_push = i_valid && o_ready;
  assign o_serial  = serial_q;
  assign o_busy    = (state_q != IDLE);
  assign bit_done  = (timer_q == '0);

  sync_fifo #(
    .width (data_bits),
    .depth (fifo_depth)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (i_data),
    .rd_data (fifo_head),
    .count   (o_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      serial_q   <= 1'b1;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      serial_q   <= serial_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
    end
  end

  // Next-state logic; serial_d is the line level for the state being entered,
  // so the registered output changes on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    serial_d    = serial_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    if (state_q != IDLE && !bit_done) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        start_frame = !fifo_empty;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          timer_d   = BIT_LOAD;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = BIT_LOAD;
          if (bit_idx_q == LAST_DATA) begin
            if (HAS_PARITY) begin
              state_d  = PARITY;
              serial_d = parity_q;
            end else begin
              state_d    = STOP;
              serial_d   = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          serial_d   = 1'b1;
          timer_d    = BIT_LOAD;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop_idx_q == STOP_LAST) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            timer_d    = BIT_LOAD;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Shared by IDLE and the end of STOP so queued words follow with no idle gap.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      parity_d = parity_bit(^fifo_head, parity_mode);
      timer_d  = BIT_LOAD;
      state_d  = START;
      serial_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations sharing one clock and reset.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_all = '0;
  logic [3:0]  v     = '0;
  logic [3:0]  rdy;
  logic [3:0]  ser;
  logic [3:0]  busy;
  logic [11:0] cnt_all;

  int vectors    = 0;
  int miscompares = 0;

  logic rec [1024];
  int   rec_n  = 0;
  bit   rec_on = 1'b0;

  always #5 clock = ~clock;

  uart_tx_fifo #(.clocks_per_bit(4), .data_bits(8), .parity_mode(PARITY_NONE),
                 .stop_bits(1), .fifo_depth(4)) u_8n1 (
    .clock(clock), .reset(reset), .i_data(d_all[7:0]), .i_valid(v[0]),
    .o_ready(rdy[0]), .o_serial(ser[0]), .o_busy(busy[0]), .o_count(cnt_all[2:0]));

  uart_tx_fifo #(.clocks_per_bit(4), .data_bits(7), .parity_mode(PARITY_EVEN),
                 .stop_bits(1), .fifo_depth(4)) u_7e1 (
    .clock(clock), .reset(reset), .i_data(d_all[14:8]), .i_valid(v[1]),
    .o_ready(rdy[1]), .o_serial(ser[1]), .o_busy(busy[1]), .o_count(cnt_all[5:3]));

  uart_tx_fifo #(.clocks_per_bit(4), .data_bits(7), .parity_mode(PARITY_ODD),
                 .stop_bits(1), .fifo_depth(4)) u_7o1 (
    .clock(clock), .reset(reset), .i_data(d_all[22:16]), .i_valid(v[2]),
    .o_ready(rdy[2]), .o_serial(ser[2]), .o_busy(busy[2]), .o_count(cnt_all[8:6]));

  uart_tx_fifo #(.clocks_per_bit(4), .data_bits(8), .parity_mode(PARITY_NONE),
                 .stop_bits(2), .fifo_depth(4)) u_8n2 (
    .clock(clock), .reset(reset), .i_data(d_all[31:24]), .i_valid(v[3]),
    .o_ready(rdy[3]), .o_serial(ser[3]), .o_busy(busy[3]), .o_count(cnt_all[11:9]));

  // Line recorder for the 8N1 instance, used to decode long multi-frame bursts.
  always @(negedge clock) begin
    if (!rec_on) begin
      rec_n <= 0;
    end else if (rec_n < 1024) begin
      rec[rec_n] <= ser[0];
      rec_n      <= rec_n + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [7:0] w);
    d_all[8*k +: 8] = w;
    v[k] = 1'b1;
    step();
    v[k] = 1'b0;
  endtask

  task automatic capture(input int k, input int n, output logic [127:0] line, output int busy_n);
    line   = '0;
    busy_n = 0;
    for (int i = 0; i < n; i++) begin
      line[i] = ser[k];
      if (busy[k]) busy_n++;
      step();
    end
  endtask

  // Each pattern bit (bit 0 first on the line) held for cpb cycles.
  function automatic logic [127:0] expand(input logic [31:0] pat, input int nbits, input int cpb);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < nbits; b++)
      for (int j = 0; j < cpb; j++)
        r[b*cpb + j] = pat[b];
    return r;
  endfunction

  // Finds the next start bit in the recording and samples 8N1 bits mid-bit (cpb = 4).
  task automatic decode(input int from, output logic [7:0] data, output logic stop, output int next);
    int idx;
    idx = from;
    while (idx < rec_n && rec[idx] !== 1'b0) idx++;
    for (int i = 0; i < 8; i++)
      data[i] = (idx + 4*(1+i) + 2 < rec_n) ? rec[idx + 4*(1+i) + 2] : 1'bx;
    stop = (idx + 38 < rec_n) ? rec[idx + 38] : 1'bx;
    next = idx + 40;
  endtask

  initial begin
    logic [127:0] line;
    logic [127:0] exp_line;
    int           bn;
    int           guard;
    int           pos;
    logic [7:0]   got;
    logic         stp;
    logic [7:0]   words [6];

    words = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h7E};

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_serial", ser, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_ready", rdy, 4'hF);
    chk("rst_count", cnt_all, 12'h000);

    // 8N1, 0x55 from idle: start bit two cycles after the push cycle
    push_word(0, 8'h55);
    chk("8n1_not_started_yet", ser[0], 1'b1);
    chk("8n1_count_after_push", cnt_all[2:0], 3'd1);
    step();
    capture(0, 40, line, bn);
    exp_line = expand(32'b1010101010, 10, 4);
    chk("8n1_line_0x55", line[39:0], exp_line[39:0]);
    chk("8n1_busy_cycles", bn, 40);
    chk("8n1_busy_after", busy[0], 1'b0);
    chk("8n1_line_idle_after", ser[0], 1'b1);

    // 7E1 and 7O1 with 0x03
    push_word(1, 8'h03);
    step();
    capture(1, 40, line, bn);
    exp_line = expand(32'b1000000110, 10, 4);
    chk("7e1_line", line[39:0], exp_line[39:0]);
    chk("7e1_parity_bit", line[32], 1'b0);
    chk("7e1_busy_cycles", bn, 40);
    chk("7e1_busy_after", busy[1], 1'b0);

    push_word(2, 8'h03);
    step();
    capture(2, 40, line, bn);
    exp_line = expand(32'b1100000110, 10, 4);
    chk("7o1_line", line[39:0], exp_line[39:0]);
    chk("7o1_parity_bit", line[32], 1'b1);
    chk("7o1_busy_cycles", bn, 40);
    chk("7o1_busy_after", busy[2], 1'b0);

    // 8N2, 0xA0 then 0x0F back-to-back
    push_word(3, 8'hA0);
    push_word(3, 8'h0F);
    capture(3, 88, line, bn);
    exp_line = expand(32'b1100001111011101000000, 22, 4);
    chk("8n2_line_two_frames", line[87:0], exp_line[87:0]);
    chk("8n2_stop_8_cycles", line[43:36], 8'hFF);
    chk("8n2_no_idle_gap", line[44], 1'b0);
    chk("8n2_busy_cycles", bn, 88);
    chk("8n2_busy_after", busy[3], 1'b0);

    // Depth 4, six words from idle: backpressure holds the sixth word
    rec_on = 1'b1;
    for (int w = 0; w < 5; w++) begin
      d_all[7:0] = words[w];
      v[0] = 1'b1;
      step();
    end
    chk("depth4_count_full", cnt_all[2:0], 3'd4);
    chk("depth4_ready_low", rdy[0], 1'b0);
    d_all[7:0] = words[5];
    repeat (10) step();
    chk("depth4_hold_count", cnt_all[2:0], 3'd4);
    chk("depth4_hold_ready", rdy[0], 1'b0);
    guard = 0;
    while (!rdy[0] && guard < 100) begin
      step();
      guard++;
    end
    chk("depth4_ready_returns", rdy[0], 1'b1);
    step();
    v[0] = 1'b0;
    guard = 0;
    while ((busy[0] || cnt_all[2:0] != 3'd0) && guard < 600) begin
      step();
      guard++;
    end
    chk("depth4_drained", busy[0], 1'b0);
    pos = 0;
    for (int w = 0; w < 6; w++) begin
      decode(pos, got, stp, pos);
      chk($sformatf("depth4_word%0d", w), got, words[w]);
      chk($sformatf("depth4_stop%0d", w), stp, 1'b1);
    end
    rec_on = 1'b0;

    // Full FIFO with same-cycle push and pop: push rejected, count drops
    for (int w = 0; w < 5; w++) begin
      d_all[7:0] = words[w];
      v[0] = 1'b1;
      step();
    end
    d_all[7:0] = 8'h99;
    repeat (36) step();
    chk("fullpop_count_before", cnt_all[2:0], 3'd4);
    chk("fullpop_ready_before", rdy[0], 1'b0);
    step();
    chk("fullpop_count_after", cnt_all[2:0], 3'd3);
    chk("fullpop_next_start", ser[0], 1'b0);
    chk("fullpop_ready_after", rdy[0], 1'b1);
    v[0] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("fullpop_reset_count", cnt_all[2:0], 3'd0);

    // Reset during DATA bit 3, then a clean 0xC3 frame
    d_all[7:0] = 8'h00;
    v[0] = 1'b1;
    step();
    d_all[7:0] = 8'h11;
    step();
    d_all[7:0] = 8'h22;
    step();
    v[0] = 1'b0;
    repeat (16) step();
    chk("midrst_line_low_bit3", ser[0], 1'b0);
    chk("midrst_busy_before", busy[0], 1'b1);
    chk("midrst_count_before", cnt_all[2:0], 3'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_serial", ser[0], 1'b1);
    chk("midrst_count", cnt_all[2:0], 3'd0);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_ready", rdy[0], 1'b1);
    repeat (3) step();
    chk("midrst_stays_idle", busy[0], 1'b0);
    push_word(0, 8'hC3);
    step();
    capture(0, 40, line, bn);
    exp_line = expand(32'b1110000110, 10, 4);
    chk("midrst_line_0xC3", line[39:0], exp_line[39:0]);
    chk("midrst_busy_after", busy[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
